// File: rtl/seven_seg_pkg.sv
// Shared definitions for 7-segment display blocks.
//   SEG_BLANK    : active-low segment code with every segment dark
//   scan_state_t : scan FSM states (SHOW a digit, BLANK gap between digits)
//   hex_to_seg() : nibble to active-low {a,b,c,d,e,f,g} code
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    code = SEG_BLANK;
    case (nib)
      4'h0: code = 7'b0000001;
      4'h1: code = 7'b1001111;
      4'h2: code = 7'b0010010;
      4'h3: code = 7'b0000110;
      4'h4: code = 7'b1001100;
      4'h5: code = 7'b0100100;
      4'h6: code = 7'b0100000;
      4'h7: code = 7'b0001111;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0000100;
      4'hA: code = 7'b0001000;
      4'hB: code = 7'b1100000;
      4'hC: code = 7'b0110001;
      4'hD: code = 7'b1000010;
      4'hE: code = 7'b0110000;
      4'hF: code = 7'b0111000;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hex_seg_encode.sv
// Combinational hex nibble to active-low 7-segment code.
//   nibble_i : 4-bit hex digit
//   seg_o    : {a,b,c,d,e,f,g}, active-low
module hex_seg_encode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver.
//   clk, reset  : clock, asynchronous active-high reset
//   value       : packed hex digits, digit 0 in bits [3:0]
//   dp_in       : decimal point per digit, 1 = lit
//   load        : captures value/dp_in into shadow registers
//   lz_suppress : blank leading zero digits (digit 0 always shown)
//   seg, dp, an : registered active-low segment, decimal point, anode drives
//   digit_idx   : registered index of the digit being driven
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  // One counter serves both the lit prescaler and the blank gap.
  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  scan_state_t             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        digit_q, digit_d, digit_next;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;

  logic [NUM_DIGITS-1:0]   an_d, an_q;
  logic [6:0]              seg_d, seg_q;
  logic                    dp_out_d, dp_out_q;
  logic [IDX_W-1:0]        idx_q;

  // Shadow registers; a load never touches scan position.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= '0;
      dp_q  <= '0;
    end else if (load) begin
      val_q <= value;
      dp_q  <= dp_in;
    end
  end

  assign digit_next = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
          end else begin
            digit_d = digit_next;
          end
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          digit_d = digit_next;
        end
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (val_q[i*4 +: 4] == 4'h0);
      lz_mask[i] = lz_suppress && zero_run;
    end
  end

  assign cur_nibble = val_q[int'(digit_q)*4 +: 4];

  hex_seg_encode u_hex_seg_encode (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  always_comb begin
    an_d     = '1;
    seg_d    = SEG_BLANK;
    dp_out_d = 1'b1;
    if (state_q == SHOW) begin
      // A suppressed digit keeps its anode on but lights nothing.
      an_d = ~(NUM_DIGITS'(1) << digit_q);
      if (!lz_mask[digit_q]) begin
        seg_d    = cur_seg;
        dp_out_d = ~dp_q[digit_q];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
      dp_out_q <= 1'b1;
      idx_q    <= '0;
    end else begin
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      idx_q    <= digit_q;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_out_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (4 digits, CLK_DIV=4, BLANK_CYCLES=1).
// The driver pushes the expected registered outputs for each clock edge; the
// monitor pops and compares them on the following falling edge.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  seven_seg_scan_driver #(
    .NUM_DIGITS   (4),
    .CLK_DIV      (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .digit_idx   (digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       chk_idx;
  } exp_t;

  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-computed expected segment code and active-low dp per digit.
  logic [6:0] tab[4];
  logic [3:0] dpo;
  int         n;  // edges since reset release; edge 1 drives digit 0

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_tab(input logic [6:0] t3, input logic [6:0] t2,
                         input logic [6:0] t1, input logic [6:0] t0, input logic [3:0] d);
    tab[3] = t3; tab[2] = t2; tab[1] = t1; tab[0] = t0;
    dpo = d;
  endtask

  // Frame: 4 digits x (4 lit + 1 blank) = 20 cycles.
  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      exp_t       e;
      int         pos;
      int         d;
      logic [3:0] one;
      @(posedge clk);
      #1;
      n++;
      pos = (n - 1) % 20;
      d   = pos / 5;
      one = 4'b0001;
      if (pos % 5 == 4) begin
        e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.idx = 2'd0; e.chk_idx = 1'b0;
      end else begin
        e.an = ~(one << d); e.seg = tab[d]; e.dp = dpo[d]; e.idx = 2'(d); e.chk_idx = 1'b1;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 40; i++) begin
      run_cycles(1);
      if ((n - 1) % 20 == target) break;
    end
  endtask

  // Load is captured on the next edge; that edge's output still shows old data.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    run_cycles(1);
    load  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},  32'(an),        32'h0000000F);
    check({tag, "_seg"}, 32'(seg),       32'h0000007F);
    check({tag, "_dp"},  32'(dp),        32'h00000001);
    check({tag, "_idx"}, 32'(digit_idx), 32'h00000000);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    check("an_at_most_one_low", 32'($countones(~an) <= 1), 32'h00000001);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("scan_an",  32'(an),  32'(e.an));
      check("scan_seg", 32'(seg), 32'(e.seg));
      check("scan_dp",  32'(dp),  32'(e.dp));
      if (e.chk_idx) check("scan_idx", 32'(digit_idx), 32'(e.idx));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; value = '0; dp_in = '0; load = 1'b0; lz_suppress = 1'b0;
    n = 0;
    set_tab(7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b1111);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;

    // Idle after reset: zeros everywhere, wraps back to digit 0 after 20 cycles.
    run_cycles(22);

    // 12AF with dp on digit 2.
    do_load(16'h12AF, 4'b0100);
    set_tab(7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000, 4'b1011);
    run_cycles(20);

    // 0050 without and then with leading-zero suppression.
    do_load(16'h0050, 4'b0000);
    set_tab(7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001, 4'b1111);
    run_cycles(20);
    lz_suppress = 1'b1;
    set_tab(7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001, 4'b1111);
    run_cycles(20);

    // All zero, suppression on: only digit 0 lit; dp of suppressed digits ignored.
    do_load(16'h0000, 4'b1111);
    set_tab(7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001, 4'b1110);
    run_until(10);

    // FFFF loaded during digit 2's SHOW; an sequence unchanged.
    do_load(16'hFFFF, 4'b0000);
    set_tab(7'b0111000, 7'b0111000, 7'b0111000, 7'b0111000, 4'b1111);
    run_until(7);

    // Asynchronous reset in the middle of digit 1's SHOW.
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("async_reset_show");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    lz_suppress = 1'b0;
    n = 0;
    set_tab(7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b1111);
    run_cycles(10);

    // Reset during digit 3's BLANK, then restart from digit 0 with cleared data.
    do_load(16'h12AF, 4'b0100);
    set_tab(7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000, 4'b1011);
    run_until(19);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("async_reset_blank");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    set_tab(7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b1111);
    run_cycles(8);

    @(negedge clk);
    #1 check("scoreboard_drained", 32'(sb_q.size()), 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display. It captures a packed hex word on a load strobe and scans one digit at a time with a programmable refresh period and an anti-ghosting blank gap. Leading-zero suppression and per-digit decimal points are provided. It sits between the processor's display register and the board pins, replacing the single-digit combinational hex decoder used on the debug display.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8
- CLK_DIV, 50000, clock cycles each digit is lit per visit; must be ≥ 2
- BLANK_CYCLES, 2, cycles with all anodes off between digits; 0 disables the gap
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high; clears all state
- value  input  4*NUM_DIGITS  packed hex digits; digit 0 = bits [3:0], the least significant
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
- load  input  1  captures value/dp_in into the shadow registers on a rising edge
- lz_suppress  input  1  enables leading-zero blanking (level, sampled every cycle)
- seg  output  7  {a,b,c,d,e,f,g}, active-low
- dp  output  1  decimal point segment, active-low
- an  output  NUM_DIGITS  anode enables, active-low, at most one low at any time
- digit_idx  output  $clog2(NUM_DIGITS) (min 1)  index of the digit currently driven

## Operation
- Shadow registers `val_q` and `dp_q` load when load=1. A load mid-scan does not disturb the scan position. New data appears at the next output update.
- Per-digit active-low encoding, hex 0..F:
  - 0000001, 1001111, 0010010, 0000110
  - 1001100, 0100100, 0100000, 0001111
  - 0000000, 0000100, 0001000, 1100000
  - 0110001, 1000010, 0110000, 0111000
- FSM states:
  - SHOW: an has bit digit_idx low; seg = encode(val_q nibble); dp = ~dp_q[digit_idx]. Prescaler counts 0..CLK_DIV-1. At CLK_DIV-1 the FSM goes to BLANK if BLANK_CYCLES>0. Otherwise it advances the digit and stays in SHOW.
  - BLANK: an = all 1s, seg = 7'b1111111, dp = 1. Counter counts 0..BLANK_CYCLES-1. At the last count the FSM advances the digit and goes to SHOW.
- Digit advance: digit_idx wraps from NUM_DIGITS-1 to 0. The prescaler clears to 0 on every state change.
- Leading-zero suppression: when lz_suppress=1, digit i (i>0) is suppressed if nibbles i..NUM_DIGITS-1 of val_q are all zero.
  - In SHOW, a suppressed digit drives seg=1111111 and dp=1, and its anode stays enabled.
  - Digit 0 is never suppressed.
  - dp_q of a suppressed digit is ignored.
- Counter width is $clog2(max(CLK_DIV, BLANK_CYCLES)). Counters never exceed their terminal value.

## Timing
- All outputs are registered. Outputs reflect the FSM/counter state from the previous edge, giving 1 cycle of latency.
- Reset (asynchronous assert, sampled release): state=SHOW, digit_idx=0, counter=0, val_q=0, dp_q=0, an=all 1s, seg=1111111, dp=1.
  - The first edge after release drives digit 0 (an=...1110, seg=0000001).
- Per-digit period is CLK_DIV+BLANK_CYCLES cycles. Frame period is NUM_DIGITS×(CLK_DIV+BLANK_CYCLES).
- load on edge k changes seg at edge k+1 at the earliest. If load and a digit advance coincide, the new digit shows the new data.
- Reset asserted mid-scan forces the reset values immediately, without waiting for a clock. The scan restarts at digit 0.
- NUM_DIGITS=1: digit_idx is constant 0. With BLANK_CYCLES>0, the blank gap still occurs.

## Structure
- Package seven_seg_pkg holds:
  - SEG_BLANK = 7'b1111111
  - the FSM state enum {SHOW, BLANK}
  - the 16-entry hex-to-segment function
- Sub-module hex_seg_encode: combinational nibble → 7-bit active-low code using the package function. It is reusable by other display blocks.
- Top module: shadow registers, prescaler, FSM, LZ mask (priority scan from MSB), output registers.

## Test plan
Configuration for all scenarios: NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1.
- Reset then idle → digit 0 lit with seg=0000001. an sequence is 1110 for 4 cycles, 1111 for 1, 1101 for 4, …, and wraps to 1110 after 20 cycles.
- load value=16'h12AF, dp_in=4'b0100 → each digit shows its own code:
  - digit0 seg=0111000
  - digit1 seg=0001000
  - digit2 seg=0010010 with dp=0
  - digit3 seg=1001111
  - dp=1 on all other digits.
- load 16'h0050, lz_suppress=1 → digits 3,2 show seg=1111111; digit1 shows 0100100; digit0 shows 0000001. With lz_suppress=0, digits 3,2 show 0000001.
- load 16'h0000 with lz_suppress=1 → only digit 0 shows 0000001. A load of 16'hFFFF during digit 2's SHOW changes seg on the next cycle without altering the an sequence.
- Assert reset mid-BLANK on digit 3 → an=1111, seg=1111111 immediately. After release, the scan restarts at digit 0 with val_q=0.
- Throughout all runs, assert that an never has more than one bit low.
